// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: data-cache miss FSM (IDLE/WRITEBACK/ALLOCATE/REFILL) driving pipeline stall, memory request, cache refill write and a saturating miss counter
module mem_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic             cache_we_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t state, state_nxt;
  logic miss;
  assign miss = (MemRead_i | MemWrite_i) & !hit_i;
  always_comb begin
    state_nxt    = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    cache_we_o   = 1'b0;
    stall_o      = !rst_i & (state != IDLE | miss);
    case (state)
      IDLE:      state_nxt = miss ? (dirty_i ? WRITEBACK : ALLOCATE) : IDLE;
      WRITEBACK: begin
        state_nxt    = mem_ack_i ? ALLOCATE : WRITEBACK;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
      end
      ALLOCATE:  begin
        state_nxt    = mem_ack_i ? REFILL : ALLOCATE;
        mem_enable_o = 1'b1;
      end
      default:   begin
        state_nxt  = IDLE;
        cache_we_o = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      miss_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the miss counter.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port MemRead_i, input, 1: load in the MEM stage (EX_MEM MemRead output).
REQ-005 SHALL have port MemWrite_i, input, 1: store in the MEM stage (EX_MEM MemWrite output).
REQ-006 SHALL have port hit_i, input, 1: data-cache tag match for the current MEM address.
REQ-007 SHALL have port dirty_i, input, 1: dirty bit of the indexed victim line.
REQ-008 SHALL have port mem_ack_i, input, 1: data memory reports the transfer complete (1-cycle pulse).
REQ-009 SHALL have port stall_o, output, 1: drives stall_i of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB).
REQ-010 SHALL have port mem_enable_o, output, 1: memory request valid.
REQ-011 SHALL have port mem_write_o, output, 1: 1 = line write-back, 0 = line fetch.
REQ-012 SHALL have port cache_we_o, output, 1: write the fetched line into the cache SRAM.
REQ-013 SHALL have port miss_cnt_o, output, CNT_W: count of misses since reset.

Function
REQ-014 SHALL implement states IDLE, WRITEBACK, ALLOCATE and REFILL, encoded in a registered state variable.
REQ-015 SHALL define access = MemRead_i OR MemWrite_i; both high together counts as one access.
REQ-016 SHALL take, in IDLE, these transitions: access & hit_i stays IDLE; access & !hit_i & dirty_i goes to WRITEBACK; access & !hit_i & !dirty_i goes to ALLOCATE; otherwise it stays IDLE.
REQ-017 SHALL hold mem_enable_o=1 and mem_write_o=1 in WRITEBACK, and move to ALLOCATE on the cycle after mem_ack_i=1.
REQ-018 SHALL hold mem_enable_o=1 and mem_write_o=0 in ALLOCATE, and move to REFILL on the cycle after mem_ack_i=1.
REQ-019 SHALL, in REFILL, drive cache_we_o=1 for exactly one cycle with mem_enable_o=0, then return unconditionally to IDLE.
REQ-020 SHALL keep cache_we_o=0 in every state other than REFILL.
REQ-021 SHALL keep mem_enable_o=0 and mem_write_o=0 in IDLE and REFILL.
REQ-022 SHALL drive stall_o combinationally: 1 in WRITEBACK, ALLOCATE and REFILL; in IDLE, stall_o = access & !hit_i, so the pipeline freezes in the same cycle the miss is seen.
REQ-023 SHALL leave stall_o=0 for the IDLE cycle after REFILL when the replayed access hits, releasing the pipeline; if it misses again, a new miss sequence starts.
REQ-024 SHALL ignore mem_ack_i in IDLE and REFILL, with no state or counter effect.
REQ-025 SHALL keep mem_enable_o asserted in WRITEBACK and ALLOCATE indefinitely until mem_ack_i arrives, with no timeout.
REQ-026 SHALL hold the state while MemRead_i/MemWrite_i change during WRITEBACK, ALLOCATE or REFILL; the sequence is not aborted.
REQ-027 SHALL increment miss_cnt_o by 1 on each IDLE-to-WRITEBACK or IDLE-to-ALLOCATE transition.
REQ-028 SHALL saturate miss_cnt_o at 2^CNT_W-1 and never wrap.
REQ-029 SHALL take the path IDLE to WRITEBACK to ALLOCATE to REFILL to IDLE for a dirty miss; a clean miss skips WRITEBACK.
REQ-030 SHALL give a clean miss with a mem_ack_i latency of L cycles a stall of L+2 cycles: the detect cycle, L-1 wait cycles, the ack cycle and REFILL.

Reset
REQ-031 SHALL, while rst_i=1, immediately and asynchronously force state=IDLE, miss_cnt_o=0, mem_enable_o=0, mem_write_o=0, cache_we_o=0 and stall_o=0, regardless of other inputs.
REQ-032 SHALL, on reset asserted mid-sequence (any non-IDLE state), drop the memory request in the same cycle without completing it; any later mem_ack_i is ignored.
REQ-033 SHALL resume normal operation on the first rising clk_i edge after rst_i deasserts.

Verification
REQ-034 SHALL be verified as follows: MemRead_i=1 and hit_i=1 held for 10 cycles gives stall_o=0 throughout, mem_enable_o=0 and miss_cnt_o=0.
REQ-035 SHALL be verified as follows: a clean miss (hit_i=0, dirty_i=0) with mem_ack_i pulsed 3 cycles after the request gives stall_o=1 for 5 cycles, mem_write_o=0, one cache_we_o pulse and miss_cnt_o=1.
REQ-036 SHALL be verified as follows: a dirty miss (MemWrite_i=1, dirty_i=1) with two acks gives mem_write_o=1 until the first ack, then 0 until the second, followed by one REFILL cycle and a return to IDLE.
REQ-037 SHALL be verified as follows: rst_i pulsed during ALLOCATE gives mem_enable_o=0 and stall_o=0 in the same cycle; an ack 2 cycles later produces no cache_we_o.
REQ-038 SHALL be verified as follows: with CNT_W=2, five consecutive clean misses leave miss_cnt_o at 3.
REQ-039 SHALL be verified as follows: mem_ack_i pulsed in IDLE with no access produces no state change and no outputs asserted.
